// File: rtl/line_refill_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : line_refill_unit_if
// Description : Cache-side miss/line signals and word-wide memory bus of the
//               line refill unit.
// Revision    : 1.0
// ============================================================================
interface line_refill_unit_if #(
    parameter int NrWordsPerLine = 4,
    parameter int LineSize       = 32 * NrWordsPerLine
);
    logic [31:0]         req_addr_i;
    logic                req_en_i;
    logic                line_valid_o;
    logic [LineSize-1:0] line_data_o;
    logic                mem_req_o;
    logic [31:0]         mem_addr_o;
    logic                mem_gnt_i;
    logic                mem_rvalid_i;
    logic [31:0]         mem_rdata_i;

    modport master (
        output req_addr_i, req_en_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  line_valid_o, line_data_o, mem_req_o, mem_addr_o
    );

    modport slave (
        input  req_addr_i, req_en_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output line_valid_o, line_data_o, mem_req_o, mem_addr_o
    );
endinterface
`default_nettype wire

// File: rtl/line_refill_unit.sv
`default_nettype none
// ============================================================================
// Module      : line_refill_unit
// Description : Fetches a cache line word by word from memory, one outstanding
//               read at a time, and returns it with a single-cycle valid pulse.
// Revision    : 1.0
// ============================================================================
module line_refill_unit #(
    parameter int NrWordsPerLine = 4,
    parameter int LineSize       = 32 * NrWordsPerLine
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    line_refill_unit_if.slave bus
);
    localparam int CNT_W = (NrWordsPerLine > 1) ? $clog2(NrWordsPerLine) : 1;
    localparam int OFF_W = CNT_W + 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [31:0]         base_q;
    logic [CNT_W-1:0]    word_cnt;
    logic [LineSize-1:0] line_q;
    logic                abort;
    logic                last_word;
    logic                mem_req;
    logic                line_valid;

    // A fill is abandoned as soon as the cache stops asking for this line.
    assign abort     = !bus.req_en_i ||
                       (bus.req_addr_i[31:OFF_W] != base_q[31:OFF_W]);
    assign last_word = (word_cnt == CNT_W'(NrWordsPerLine - 1));

    assign bus.mem_req_o    = mem_req;
    assign bus.mem_addr_o   = base_q + {{(32-OFF_W){1'b0}}, word_cnt, 2'b00};
    assign bus.line_valid_o = line_valid;
    assign bus.line_data_o  = line_q;

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        line_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_en_i) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                mem_req = 1'b1;
                if (abort)              state_d = bus.mem_gnt_i ? S_DRAIN : S_IDLE;
                else if (bus.mem_gnt_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_rvalid_i) begin
                    if (abort)          state_d = S_IDLE;
                    else if (last_word) state_d = S_DONE;
                    else                state_d = S_ISSUE;
                end else if (abort) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.mem_rvalid_i) state_d = S_IDLE;
            end
            S_DONE: begin
                line_valid = bus.req_en_i && !abort;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            word_cnt <= '0;
            line_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (bus.req_en_i) begin
                        base_q   <= {bus.req_addr_i[31:OFF_W], {OFF_W{1'b0}}};
                        word_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_rvalid_i) begin
                        line_q[32*int'(word_cnt) +: 32] <= bus.mem_rdata_i;
                        if (!abort && !last_word) word_cnt <= word_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_line_refill_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_refill_unit
// Description : Self-checking bench for line_refill_unit with a latency-
//               configurable memory model and line/address scoreboards.
// Revision    : 1.0
// ============================================================================
module tb_line_refill_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    line_refill_unit_if #(.NrWordsPerLine(4)) bus ();

    line_refill_unit #(.NrWordsPerLine(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [127:0] line;
        int           cyc;
    } exp_t;

    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    exp_t         sb_q[$];
    logic [31:0]  addr_q[$];

    int           gnt_dly  = 0;
    int           rv_dly   = 1;
    bit           mem_hold = 1'b0;
    bit           rv_pending = 1'b0;
    int           rv_wait  = 0;
    int           gnt_wait = 0;
    logic [31:0]  pend_addr = '0;
    bit           prev_ungranted = 1'b0;
    logic [31:0]  prev_addr = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h0000123) return 32'hA0 + {30'b0, a[3:2]};
        return a ^ 32'h5EED_0000;
    endfunction

    function automatic logic [127:0] line_of(input logic [31:0] base);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = mem_word(base + 32'(4*k));
        return l;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_addrs(input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) addr_q.push_back(base + 32'(4*k));
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: fixed grant/rvalid latency, one read in flight.
    initial begin
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            bus.mem_gnt_i    = 1'b0;
            bus.mem_rvalid_i = 1'b0;
            check("one_outstanding", {127'b0, bus.mem_req_o && rv_pending}, 128'd0);
            if (prev_ungranted)
                check("req_hold", {95'b0, bus.mem_req_o, bus.mem_addr_o}, {95'b0, 1'b1, prev_addr});
            if (rv_pending) begin
                if (rv_wait == 0) begin
                    bus.mem_rvalid_i = 1'b1;
                    bus.mem_rdata_i  = mem_word(pend_addr);
                    rv_pending       = 1'b0;
                end else begin
                    rv_wait--;
                end
            end
            prev_ungranted = 1'b0;
            if (bus.mem_req_o === 1'b1) begin
                if (gnt_wait == 0 && !mem_hold) begin
                    bus.mem_gnt_i = 1'b1;
                    if (addr_q.size() == 0) check("gnt_extra", 128'd1, 128'd0);
                    else check("gnt_addr", {96'b0, bus.mem_addr_o}, {96'b0, addr_q.pop_front()});
                    pend_addr  = bus.mem_addr_o;
                    rv_pending = 1'b1;
                    rv_wait    = rv_dly - 1;
                    gnt_wait   = gnt_dly;
                end else begin
                    if (gnt_wait > 0) gnt_wait--;
                    prev_ungranted = bus.req_en_i &&
                                     (bus.req_addr_i[31:4] == bus.mem_addr_o[31:4]);
                    prev_addr      = bus.mem_addr_o;
                end
            end else begin
                gnt_wait = gnt_dly;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (bus.line_valid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("valid_extra", 128'd1, 128'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("line_data", bus.line_data_o, e.line);
                check("line_cyc", 128'(cyc), 128'(e.cyc));
            end
        end
    end

    initial begin
        rst            = 1'b1;
        bus.req_en_i   = 1'b0;
        bus.req_addr_i = '0;
        step(3);
        check("rst_valid", {127'b0, bus.line_valid_o}, 128'd0);
        check("rst_req",   {127'b0, bus.mem_req_o}, 128'd0);
        check("rst_data",  bus.line_data_o, 128'd0);
        check("rst_addr",  {96'b0, bus.mem_addr_o}, 128'd0);
        rst = 1'b0;
        step(2);

        // Zero-wait fill
        gnt_dly = 0; rv_dly = 1;
        bus.req_addr_i = 32'h0000_1238;
        bus.req_en_i   = 1'b1;
        sb_q.push_back('{128'h000000A3_000000A2_000000A1_000000A0, cyc + 9});
        push_addrs(32'h0000_1230, 4);
        step(10);
        bus.req_en_i = 1'b0;
        step(2);

        // Stalled memory
        gnt_dly = 2; rv_dly = 3;
        step(1);
        bus.req_addr_i = 32'h0000_4440;
        bus.req_en_i   = 1'b1;
        sb_q.push_back('{line_of(32'h0000_4440), cyc + 25});
        push_addrs(32'h0000_4440, 4);
        step(26);
        bus.req_en_i = 1'b0;
        step(2);

        // Abort while waiting for word 1
        gnt_dly = 0; rv_dly = 3;
        step(1);
        bus.req_addr_i = 32'h0000_0300;
        bus.req_en_i   = 1'b1;
        push_addrs(32'h0000_0300, 2);
        step(6);
        bus.req_en_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("drain_noreq", {127'b0, bus.mem_req_o}, 128'd0);
        end
        step(3);

        // Address change while ungranted
        rv_dly = 1; mem_hold = 1'b1;
        step(1);
        bus.req_addr_i = 32'h0000_1500;
        bus.req_en_i   = 1'b1;
        step(3);
        bus.req_addr_i = 32'h0000_2000;
        step(1);
        check("withdraw", {127'b0, bus.mem_req_o}, 128'd0);
        mem_hold = 1'b0;
        sb_q.push_back('{line_of(32'h0000_2000), cyc + 9});
        push_addrs(32'h0000_2000, 4);
        step(10);
        bus.req_en_i = 1'b0;
        step(2);

        // Reset during word 2 wait
        rv_dly = 3;
        step(1);
        bus.req_addr_i = 32'h0000_5550;
        bus.req_en_i   = 1'b1;
        push_addrs(32'h0000_5550, 3);
        step(10);
        rst          = 1'b1;
        bus.req_en_i = 1'b0;
        step(1);
        check("mid_rst_valid", {127'b0, bus.line_valid_o}, 128'd0);
        check("mid_rst_req",   {127'b0, bus.mem_req_o}, 128'd0);
        check("mid_rst_data",  bus.line_data_o, 128'd0);
        check("mid_rst_addr",  {96'b0, bus.mem_addr_o}, 128'd0);
        rst = 1'b0;
        step(2);
        check("rst_rv_ignored", bus.line_data_o, 128'd0);
        check("rst_idle_req", {127'b0, bus.mem_req_o}, 128'd0);
        step(2);

        // Back-to-back lines
        rv_dly = 1;
        step(1);
        bus.req_addr_i = 32'h0000_0100;
        bus.req_en_i   = 1'b1;
        sb_q.push_back('{line_of(32'h0000_0100), cyc + 9});
        push_addrs(32'h0000_0100, 4);
        step(10);
        bus.req_addr_i = 32'h0000_0200;
        sb_q.push_back('{line_of(32'h0000_0200), cyc + 9});
        push_addrs(32'h0000_0200, 4);
        step(10);
        bus.req_en_i = 1'b0;
        step(3);

        for (int i = 0; i < 100 && (sb_q.size() != 0 || addr_q.size() != 0); i++) step(1);
        check("sb_empty",     128'(sb_q.size()), 128'd0);
        check("addr_q_empty", 128'(addr_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
